// File: rtl/dout_uart_tx_pkg.sv
// Shared types and constants for the dout UART transmitter.
// Frame shape is fixed 8N1: one start bit, eight data bits, one stop bit.
package dout_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int BITS_PER_BYTE = 8;
    localparam int FRAME_BITS    = 10;

endpackage

// File: rtl/dout_uart_tx_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          sys_rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_level;

    logic w_do_pop;
    logic w_do_push;

    assign full      = (r_level == (PTR_W+1)'(FIFO_DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (PTR_W+1)'(1);
                2'b01:   r_level <= r_level - (PTR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/dout_uart_tx.sv
// Watches the core dout bus, queues every change and streams each word out
// on an 8N1 UART line as two bytes, high byte first.
module dout_uart_tx
    import dout_uart_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        sys_rst_n,
    input  logic [DATA_W-1:0]           dout_in,
    input  logic                        cap_en,
    input  logic                        ovf_clr,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                BIT_W     = $clog2(BITS_PER_BYTE);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_BYTE - 1);

    logic [DATA_W-1:0]        r_last_dout;
    logic                     r_overflow;
    state_t                   r_state;
    logic [BAUD_W-1:0]        r_baud;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic [BITS_PER_BYTE-1:0] r_shift;
    logic [DATA_W-1:0]        r_hold;
    logic                     r_byte_sel;
    logic                     r_tx;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_baud_done;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [DATA_W-1:0]        w_fifo_rdata;

    assign w_push      = cap_en && (dout_in != r_last_dout);
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_pop       = !w_fifo_empty &&
                         ((r_state == IDLE) ||
                          ((r_state == STOP) && w_baud_done && r_byte_sel));

    assign tx       = r_tx;
    assign overflow = r_overflow;
    assign busy     = (r_state != IDLE) || !w_fifo_empty;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .wdata     (dout_in),
        .rdata     (w_fifo_rdata),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .level     (fifo_level)
    );

    // The last-seen value follows every detected change, even one the FIFO drops.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last_dout <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_last_dout <= dout_in;
            end
            if (w_push && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_hold     <= '0;
            r_byte_sel <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (!w_fifo_empty) begin
                        r_hold     <= w_fifo_rdata;
                        r_shift    <= w_fifo_rdata[DATA_W-1 -: BITS_PER_BYTE];
                        r_byte_sel <= 1'b0;
                        r_tx       <= 1'b0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[BITS_PER_BYTE-1:1]};
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (!r_byte_sel) begin
                            r_shift    <= r_hold[BITS_PER_BYTE-1:0];
                            r_byte_sel <= 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else if (!w_fifo_empty) begin
                            // Back-to-back words go straight into the next start bit.
                            r_hold     <= w_fifo_rdata;
                            r_shift    <= w_fifo_rdata[DATA_W-1 -: BITS_PER_BYTE];
                            r_byte_sel <= 1'b0;
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dout_uart_tx.sv
// Self-checking bench for dout_uart_tx: directed scenarios plus random traffic,
// all compared every cycle against a queue-and-timeline model of the line.
module tb_dout_uart_tx;

    localparam int CPB      = 4;
    localparam int DEPTH    = 4;
    localparam int WORD_CYC = 20 * CPB;

    logic        clk;
    logic        rstN;
    logic [15:0] dout;
    logic        capEn;
    logic        ovfClr;
    logic        txLine;
    logic        busyOut;
    logic        ovfOut;
    logic [2:0]  fifoLevel;

    int checkCount = 0;
    int errorCount = 0;

    // Model state: words waiting, the word on the line and when it was popped.
    logic [15:0] wordQ[$];
    logic [15:0] curWord;
    logic [15:0] lastDout;
    bit          active;
    bit          ovfModel;
    int          edgeNum;
    int          popEdge;

    dout_uart_tx #(
        .DATA_W       (16),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .sys_rst_n  (rstN),
        .dout_in    (dout),
        .cap_en     (capEn),
        .ovf_clr    (ovfClr),
        .tx         (txLine),
        .busy       (busyOut),
        .overflow   (ovfOut),
        .fifo_level (fifoLevel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        wordQ.delete();
        curWord  = '0;
        lastDout = '0;
        active   = 1'b0;
        ovfModel = 1'b0;
        popEdge  = 0;
    endtask

    // One rising edge of the model: finish/start a word, then accept or drop a capture.
    task automatic modelEdge();
        bit dropped;
        dropped = 1'b0;
        edgeNum++;
        if (!rstN) begin
            modelReset();
            return;
        end
        if (active && (edgeNum - popEdge == WORD_CYC)) begin
            active = 1'b0;
        end
        if (!active && wordQ.size() > 0) begin
            curWord = wordQ.pop_front();
            active  = 1'b1;
            popEdge = edgeNum;
        end
        if (capEn && dout != lastDout) begin
            lastDout = dout;
            if (wordQ.size() < DEPTH) begin
                wordQ.push_back(dout);
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) begin
            ovfModel = 1'b1;
        end else if (ovfClr) begin
            ovfModel = 1'b0;
        end
    endtask

    function automatic logic expectedTx();
        int k;
        int slot;
        int b;
        logic [7:0] byteVal;
        if (!active) return 1'b1;
        k       = edgeNum - popEdge;
        slot    = k / CPB;
        b       = slot % 10;
        byteVal = (slot < 10) ? curWord[15:8] : curWord[7:0];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return byteVal[b-1];
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("tx", 32'(txLine), 32'(expectedTx()));
        checkOutput("busy", 32'(busyOut), 32'(active || wordQ.size() > 0));
        checkOutput("level", 32'(fifoLevel), 32'(wordQ.size()));
        checkOutput("overflow", 32'(ovfOut), 32'(ovfModel));
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic ce, input logic oc);
        dout   = d;
        capEn  = ce;
        ovfClr = oc;
        stepCycle();
    endtask

    task automatic drainIdle(input int limit);
        int n;
        n = 0;
        while (busyOut && n < limit) begin
            applyStimulus(dout, capEn, 1'b0);
            n++;
        end
        checkOutput("drain_timeout", 32'(busyOut), 32'd0);
    endtask

    initial begin
        int busyLen;
        int lowCount;
        int n;
        bit burst;

        rstN    = 1'b0;
        dout    = '0;
        capEn   = 1'b0;
        ovfClr  = 1'b0;
        edgeNum = 0;
        modelReset();

        repeat (3) stepCycle();
        checkOutput("reset_tx", 32'(txLine), 32'd1);
        checkOutput("reset_busy", 32'(busyOut), 32'd0);
        checkOutput("reset_level", 32'(fifoLevel), 32'd0);
        checkOutput("reset_ovf", 32'(ovfOut), 32'd0);
        rstN = 1'b1;
        applyStimulus(16'h0000, 1'b1, 1'b0);

        // Single word 0x001F: tx falls one edge after the push, busy lasts 80 cycles.
        applyStimulus(16'h001F, 1'b1, 1'b0);
        checkOutput("push_level", 32'(fifoLevel), 32'd1);
        checkOutput("push_tx_high", 32'(txLine), 32'd1);
        applyStimulus(16'h001F, 1'b1, 1'b0);
        checkOutput("tx_fall", 32'(txLine), 32'd0);
        busyLen = 0;
        n = 0;
        while (busyOut && n < 200) begin
            busyLen++;
            applyStimulus(16'h001F, 1'b1, 1'b0);
            n++;
        end
        checkOutput("busy_len", 32'(busyLen), 32'd80);

        // Constant 0x1234 for 200 cycles sends exactly one word.
        repeat (200) applyStimulus(16'h1234, 1'b1, 1'b0);
        checkOutput("const_level", 32'(fifoLevel), 32'd0);
        checkOutput("const_busy", 32'(busyOut), 32'd0);

        // Six back-to-back values: first is popped, next four fill, sixth drops.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(16'hA000 + 16'(i), 1'b1, 1'b0);
        end
        checkOutput("burst_level", 32'(fifoLevel), 32'd4);
        checkOutput("burst_ovf", 32'(ovfOut), 32'd1);
        applyStimulus(16'hA006, 1'b1, 1'b1);
        checkOutput("ovf_clr", 32'(ovfOut), 32'd0);

        // Push lands on the edge where the end of STOP pops from the full FIFO.
        n = 0;
        while (!(active && (edgeNum + 1 - popEdge == WORD_CYC)) && n < 200) begin
            applyStimulus(16'hA006, 1'b1, 1'b0);
            n++;
        end
        checkOutput("wait_stop_end", 32'(n < 200), 32'd1);
        applyStimulus(16'hB00B, 1'b1, 1'b0);
        checkOutput("full_pushpop_level", 32'(fifoLevel), 32'd4);
        checkOutput("full_pushpop_ovf", 32'(ovfOut), 32'd0);
        drainIdle(6 * WORD_CYC);

        // No capture while disabled; one capture once re-enabled.
        repeat (5) applyStimulus(16'h0001, 1'b0, 1'b0);
        repeat (5) applyStimulus(16'h0002, 1'b0, 1'b0);
        checkOutput("capoff_level", 32'(fifoLevel), 32'd0);
        checkOutput("capoff_busy", 32'(busyOut), 32'd0);
        applyStimulus(16'h0002, 1'b1, 1'b0);
        checkOutput("capon_level", 32'(fifoLevel), 32'd1);
        repeat (3) applyStimulus(16'h0002, 1'b1, 1'b0);
        checkOutput("capon_single", 32'(fifoLevel), 32'd0);
        drainIdle(2 * WORD_CYC);

        // Asynchronous reset during data bit 3 of the high byte.
        applyStimulus(16'hC35A, 1'b1, 1'b0);
        applyStimulus(16'hC35B, 1'b1, 1'b0);
        n = 0;
        while (!(active && (edgeNum - popEdge == 4 * CPB + 1)) && n < 100) begin
            applyStimulus(16'hC35B, 1'b1, 1'b0);
            n++;
        end
        checkOutput("wait_bit3", 32'(n < 100), 32'd1);
        #2;
        rstN = 1'b0;
        dout = 16'h0000;
        #1;
        checkOutput("arst_tx", 32'(txLine), 32'd1);
        checkOutput("arst_level", 32'(fifoLevel), 32'd0);
        checkOutput("arst_ovf", 32'(ovfOut), 32'd0);
        checkOutput("arst_busy", 32'(busyOut), 32'd0);
        repeat (2) stepCycle();
        rstN = 1'b1;
        lowCount = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(16'h0000, 1'b1, 1'b0);
            if (!txLine) lowCount++;
        end
        checkOutput("post_reset_quiet", 32'(lowCount), 32'd0);

        // Random traffic: alternating quiet and burst phases from a small value pool.
        burst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            logic        ce;
            logic        oc;
            if ($urandom_range(0, 99) == 0) burst = ~burst;
            d  = dout;
            if (burst || $urandom_range(0, 39) == 0) begin
                d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
            end
            ce = ($urandom_range(0, 9) != 0);
            oc = ($urandom_range(0, 24) == 0);
            applyStimulus(d, ce, oc);
        end
        drainIdle(6 * WORD_CYC);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
